tele_rx: RTL and testbench
==========================

Name: tele_rx

Overview:
Serial receiver for the 16-bit telemetry frame emitted by the tele transmitter: one bit per clk, line idle low.
Synchronises the line, finds frame start, and shifts in all 16 bits. Checks preamble and parity, then presents address/data with a one-cycle valid pulse.
Sits at the far end of the tele link, feeding the game-side register decode and a health/statistics readout.

Parameters:
SYNC_STAGES, 2, input synchroniser depth (legal 1..3).
GAP_MIN, 8, consecutive low samples required before re-arming for a new frame (legal 1..255).

Ports:
clk  in  1  system clock, 100 MHz, same rate as transmitter bit clock
rst  in  1  asynchronous, active-high reset
i_rx  in  1  serial line, idle 0
o_rx_flag  out  1  one-cycle pulse: good frame received
o_rx_addr  out  7  frame address; valid with o_rx_flag, else 0
o_rx_data  out  4  frame data; valid with o_rx_flag, else 0
o_rx_err  out  1  one-cycle pulse: bad frame (preamble or parity)
o_err_pre  out  1  qualifies o_rx_err: preamble mismatch
o_err_par  out  1  qualifies o_rx_err: parity failure
o_frame_cnt  out  16  good-frame count, wraps
o_err_cnt  out  8  bad-frame count, saturates at 255
o_busy  out  1  high while in S_RUN

Behaviour:
- Frame format, bit 0 first on the line: b0..b3 = 1,0,1,0 preamble; b4..b10 = addr[6:0], MSB first; b11..b14 = data[3:0], MSB first; b15 = XOR of b0..b14.
- Good frame = preamble matches AND XOR(b0..b15) == 0.
- Synchroniser: SYNC_STAGES flops, reset to 0; s_rx is the last stage.
- States:
  - S_GAP: count consecutive s_rx==0 samples. A 1 clears the count. Count reaching GAP_MIN -> S_IDLE.
  - S_IDLE: s_rx==1 -> S_RUN. That sample is captured as b0 and the bit counter is set to 1.
  - S_RUN: capture s_rx every cycle into a 16-bit shift register. On capturing b15 (counter==15) -> S_GAP with gap count 0.
- Frame length is fixed: no early abort, and no preamble check until all 16 bits are in.
- Evaluation happens on the same edge that captures b15; outputs are registered.
- Latency: if the parity bit is on i_rx during cycle P, o_rx_flag/o_rx_err is high in cycle P+SYNC_STAGES+1, for exactly one cycle.
- o_rx_flag and o_rx_err are mutually exclusive. o_err_pre and o_err_par may both be 1; both are 0 whenever o_rx_err==0.
- o_rx_addr/o_rx_data are 0 in every cycle where o_rx_flag==0, including bad frames.
- Counters:
  - o_frame_cnt += 1 on each o_rx_flag, wrapping 0xFFFF -> 0.
  - o_err_cnt += 1 on each o_rx_err, holding at 255.
  - Both counters update in the cycle after the pulse is asserted.
- Reset (asynchronous, any time, including mid-frame):
  - state = S_GAP, gap count = 0, bit counter = 0, shift register = 0.
  - All outputs and counters = 0.
  - Because reset enters S_GAP, a frame in flight at reset release is discarded until GAP_MIN zeros have been seen.
- Line stuck high: remains in S_GAP; no pulses, no counter change.
- Back-to-back frames with a gap shorter than GAP_MIN: the second frame is not detected. Its high bits keep resetting the gap count, so no spurious frame is formed. The transmitter's inter-frame gap is at least 21 cycles.

Decomposition:
- Shared package tele_pkg:
  - TELE_FRAME_LEN=16, TELE_PREAMBLE=4'b1010, TELE_ADDR_W=7, TELE_DATA_W=4.
  - Field bit positions.
  - Receiver state encodings S_GAP/S_IDLE/S_RUN.
- Sub-module tele_sync: parameterised N-stage reset-to-0 synchroniser, reusable by other link inputs.
- Shifting, checking and counters stay in tele_rx.

Test Plan:
- Reset, hold i_rx=0 for 8 cycles, then send addr=0x00 data=0x0 (line 1010_0000000_0000_0) -> o_rx_flag at P+3, addr=0, data=0, o_frame_cnt=1.
- Send addr=0x25 data=0x5 (line 1010_0100101_0101_1), then loop the transmitter over addr 0..127 -> every frame flagged with data==addr[3:0], o_frame_cnt=129 after the loop, o_err_cnt=0.
- Flip b15 of addr=0x25 frame -> o_rx_err=1, o_err_par=1, o_err_pre=0, addr/data=0, o_err_cnt=1, o_frame_cnt unchanged.
- Send 1110_0000000_0000_1 (bad preamble, parity even) -> o_err_pre=1, o_err_par=0; then 1110_0000000_0000_0 -> both error bits set.
- Assert rst at bit 7 of a frame, release at bit 9 -> no flag/err for that frame, outputs 0; next frame after ≥8 low cycles is received correctly.
- Two valid frames with 3-cycle gap (GAP_MIN=8) -> only first flagged; 300 forced parity errors -> o_err_cnt holds 255.

Source files
------------

// File: rtl/tele_pkg.sv
// Shared definitions for the tele serial link: frame layout, field positions and receiver states.
package tele_pkg;

    localparam int TELE_FRAME_LEN = 16;
    localparam int TELE_ADDR_W    = 7;
    localparam int TELE_DATA_W    = 4;
    localparam logic [3:0] TELE_PREAMBLE = 4'b1010;

    // Positions inside a 16-bit frame word where bit 15 holds b0 (first on the line).
    localparam int TELE_PRE_MSB  = 15;
    localparam int TELE_PRE_LSB  = 12;
    localparam int TELE_ADDR_MSB = 11;
    localparam int TELE_ADDR_LSB = 5;
    localparam int TELE_DATA_MSB = 4;
    localparam int TELE_DATA_LSB = 1;

    typedef enum logic [1:0] {
        S_GAP  = 2'd0,
        S_IDLE = 2'd1,
        S_RUN  = 2'd2
    } tele_rx_state_e;

    function automatic logic tele_parity_ok(input logic [TELE_FRAME_LEN-1:0] frame);
        return ~(^frame);
    endfunction

endpackage

// File: rtl/tele_sync.sv
// N-stage synchroniser for an asynchronous single-bit input; all stages reset to 0.
module tele_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] stage_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < N; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[N-1];

endmodule

// File: rtl/tele_rx.sv
// Telemetry frame receiver: gap-armed start detection, 16-bit capture, preamble/parity check.
// Result pulses appear SYNC_STAGES+1 cycles after the parity bit is on the line.
import tele_pkg::*;

module tele_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int GAP_MIN     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_rx,
    output logic                   o_rx_flag,
    output logic [TELE_ADDR_W-1:0] o_rx_addr,
    output logic [TELE_DATA_W-1:0] o_rx_data,
    output logic                   o_rx_err,
    output logic                   o_err_pre,
    output logic                   o_err_par,
    output logic [15:0]            o_frame_cnt,
    output logic [7:0]             o_err_cnt,
    output logic                   o_busy
);

    localparam logic [8:0] GAP_LIM = 9'(GAP_MIN);

    logic s_rx;

    tele_sync #(.N(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (i_rx),
        .q_o (s_rx)
    );

    tele_rx_state_e               state_q;
    logic [7:0]                   gap_q;
    logic [3:0]                   bit_q;
    logic [TELE_FRAME_LEN-2:0]    shreg_q;
    logic                         rx_flag_q, rx_err_q, err_pre_q, err_par_q;
    logic [TELE_ADDR_W-1:0]       rx_addr_q;
    logic [TELE_DATA_W-1:0]       rx_data_q;
    logic [15:0]                  frame_cnt_q;
    logic [7:0]                   err_cnt_q;

    // Full frame as seen on the edge that captures b15: the 15 stored bits plus the live sample.
    logic [TELE_FRAME_LEN-1:0] frame;
    logic [8:0]                gap_nxt;
    logic                      pre_ok, par_ok;

    assign frame   = {shreg_q, s_rx};
    assign gap_nxt = {1'b0, gap_q} + 9'd1;
    assign pre_ok  = (frame[TELE_PRE_MSB:TELE_PRE_LSB] == TELE_PREAMBLE);
    assign par_ok  = tele_parity_ok(frame);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_GAP;
            gap_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            rx_flag_q <= 1'b0;
            rx_err_q  <= 1'b0;
            err_pre_q <= 1'b0;
            err_par_q <= 1'b0;
            rx_addr_q <= '0;
            rx_data_q <= '0;
        end else begin
            rx_flag_q <= 1'b0;
            rx_err_q  <= 1'b0;
            err_pre_q <= 1'b0;
            err_par_q <= 1'b0;
            rx_addr_q <= '0;
            rx_data_q <= '0;
            case (state_q)
                S_GAP: begin
                    if (s_rx) begin
                        gap_q <= '0;
                    end else if (gap_nxt >= GAP_LIM) begin
                        gap_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_nxt[7:0];
                    end
                end
                S_IDLE: begin
                    if (s_rx) begin
                        shreg_q <= {{(TELE_FRAME_LEN-2){1'b0}}, s_rx};
                        bit_q   <= 4'd1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    shreg_q <= frame[TELE_FRAME_LEN-2:0];
                    bit_q   <= bit_q + 4'd1;
                    if (bit_q == 4'd15) begin
                        state_q <= S_GAP;
                        gap_q   <= '0;
                        bit_q   <= '0;
                        if (pre_ok && par_ok) begin
                            rx_flag_q <= 1'b1;
                            rx_addr_q <= frame[TELE_ADDR_MSB:TELE_ADDR_LSB];
                            rx_data_q <= frame[TELE_DATA_MSB:TELE_DATA_LSB];
                        end else begin
                            rx_err_q  <= 1'b1;
                            err_pre_q <= ~pre_ok;
                            err_par_q <= ~par_ok;
                        end
                    end
                end
                default: state_q <= S_GAP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (rx_flag_q) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (rx_err_q && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign o_rx_flag   = rx_flag_q;
    assign o_rx_addr   = rx_addr_q;
    assign o_rx_data   = rx_data_q;
    assign o_rx_err    = rx_err_q;
    assign o_err_pre   = err_pre_q;
    assign o_err_par   = err_par_q;
    assign o_frame_cnt = frame_cnt_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_busy      = (state_q == S_RUN);

endmodule

// File: tb/tb_tele_rx.sv
// Scoreboard bench for tele_rx: directed frames queue expected pulses, a negedge monitor checks them.
module tb_tele_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_rx = 1'b0;
    logic        o_rx_flag, o_rx_err, o_err_pre, o_err_par, o_busy;
    logic [6:0]  o_rx_addr;
    logic [3:0]  o_rx_data;
    logic [15:0] o_frame_cnt;
    logic [7:0]  o_err_cnt;

    tele_rx #(.SYNC_STAGES(2), .GAP_MIN(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx        (i_rx),
        .o_rx_flag   (o_rx_flag),
        .o_rx_addr   (o_rx_addr),
        .o_rx_data   (o_rx_data),
        .o_rx_err    (o_rx_err),
        .o_err_pre   (o_err_pre),
        .o_err_par   (o_err_par),
        .o_frame_cnt (o_frame_cnt),
        .o_err_cnt   (o_err_cnt),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    localparam int K_NONE = 0, K_GOOD = 1, K_PAR = 2, K_PRE = 3, K_BOTH = 4;

    typedef struct {
        logic       flag;
        logic       err;
        logic       pre;
        logic       par;
        logic [6:0] addr;
        logic [3:0] data;
        int         cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    logic [15:0] exp_fc = '0;
    logic [7:0]  exp_ec = '0;
    bit          cnt_pending = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares pulses against the scoreboard and counters one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt_pending = 0;
            end else begin
                if (cnt_pending) begin
                    chk("frame_cnt", 32'(o_frame_cnt), 32'(exp_fc));
                    chk("err_cnt", 32'(o_err_cnt), 32'(exp_ec));
                    cnt_pending = 0;
                end
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    chk("frame_result",
                        32'({o_rx_flag, o_rx_err, o_err_pre, o_err_par, o_rx_addr, o_rx_data}),
                        32'({e.flag, e.err, e.pre, e.par, e.addr, e.data}));
                    if (e.flag) exp_fc = exp_fc + 16'd1;
                    else if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
                    cnt_pending = 1;
                end else if (o_rx_flag || o_rx_err || o_err_pre || o_err_par ||
                             o_rx_addr != 7'd0 || o_rx_data != 4'd0) begin
                    chk("unexpected_output",
                        32'({o_rx_flag, o_rx_err, o_err_pre, o_err_par, o_rx_addr, o_rx_data}), 32'd0);
                end
            end
        end
    end

    task automatic tick(input logic b);
        @(posedge clk);
        #1 i_rx = b;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0);
    endtask

    task automatic send(input logic [15:0] w, input int kind, input logic [6:0] a, input logic [3:0] d);
        exp_t e;
        for (int i = 15; i >= 0; i--) begin
            tick(w[i]);
            if (kind != K_NONE && i == 7) chk("busy_mid_frame", 32'(o_busy), 32'd1);
        end
        if (kind != K_NONE) begin
            e.flag = (kind == K_GOOD);
            e.err  = (kind != K_GOOD);
            e.pre  = (kind == K_PRE) || (kind == K_BOTH);
            e.par  = (kind == K_PAR) || (kind == K_BOTH);
            e.addr = (kind == K_GOOD) ? a : 7'd0;
            e.data = (kind == K_GOOD) ? d : 4'd0;
            e.cyc  = cyc + 3;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        idle(3);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        i_rx = 1'b0;
        sb.delete();
        exp_fc = '0;
        exp_ec = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic [15:0] mk(input logic [6:0] a, input logic [3:0] d);
        logic [14:0] body;
        body = {4'b1010, a, d};
        return {body, ^body};
    endfunction

    localparam logic [15:0] F00     = 16'b1010_0000000_0000_0;
    localparam logic [15:0] F25     = 16'b1010_0100101_0101_1;
    localparam logic [15:0] F25_BAD = 16'b1010_0100101_0101_0;
    localparam logic [15:0] F_PRE   = 16'b1110_0000000_0000_1;
    localparam logic [15:0] F_BOTH  = 16'b1110_0000000_0000_0;
    localparam logic [15:0] F_PAR   = 16'b1010_0000000_0000_1;

    initial begin
        logic [6:0] a;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flag", 32'(o_rx_flag), 32'd0);
        chk("rst_err", 32'(o_rx_err), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
        chk("rst_err_cnt", 32'(o_err_cnt), 32'd0);
        chk("rst_addr_data", 32'({o_rx_addr, o_rx_data}), 32'd0);
        rst = 1'b0;

        idle(8);
        send(F00, K_GOOD, 7'h00, 4'h0);
        idle(21);
        drain();
        chk("cnt_after_first", 32'(o_frame_cnt), 32'd1);

        do_reset();
        idle(8);
        send(F25, K_GOOD, 7'h25, 4'h5);
        idle(21);
        for (int i = 0; i < 128; i++) begin
            a = 7'(i);
            send(mk(a, a[3:0]), K_GOOD, a, a[3:0]);
            idle(21);
        end
        drain();
        chk("cnt_after_loop", 32'(o_frame_cnt), 32'd129);
        chk("err_after_loop", 32'(o_err_cnt), 32'd0);

        send(F25_BAD, K_PAR, 7'h25, 4'h5);
        idle(21);
        drain();
        chk("err_cnt_parity", 32'(o_err_cnt), 32'd1);
        chk("frame_cnt_hold", 32'(o_frame_cnt), 32'd129);

        send(F_PRE, K_PRE, 7'h0, 4'h0);
        idle(21);
        send(F_BOTH, K_BOTH, 7'h0, 4'h0);
        idle(21);
        drain();
        chk("err_cnt_pre", 32'(o_err_cnt), 32'd3);

        // Reset asserted while bit 7 is on the line, released at bit 9.
        for (int j = 0; j < 16; j++) begin
            tick(F25[15-j]);
            if (j == 7) begin
                rst = 1'b1;
                sb.delete();
                exp_fc = '0;
                exp_ec = '0;
            end
            if (j == 8) chk("midrst_outputs",
                32'({o_rx_flag, o_rx_err, o_busy, o_frame_cnt, o_err_cnt}), 32'd0);
            if (j == 9) rst = 1'b0;
        end
        idle(21);
        send(F00, K_GOOD, 7'h00, 4'h0);
        idle(21);
        drain();
        chk("cnt_after_midrst", 32'(o_frame_cnt), 32'd1);

        send(F25, K_GOOD, 7'h25, 4'h5);
        idle(3);
        send(F00, K_NONE, 7'h0, 4'h0);
        idle(21);
        drain();
        chk("cnt_short_gap", 32'(o_frame_cnt), 32'd2);

        for (int i = 0; i < 300; i++) begin
            send(F_PAR, K_PAR, 7'h0, 4'h0);
            idle(21);
        end
        drain();
        chk("err_cnt_saturate", 32'(o_err_cnt), 32'd255);
        chk("frame_cnt_final", 32'(o_frame_cnt), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
